dsp_pipe_delay_line: RTL

- Parametrised successor to the single optional DSP48A1 input/output register.
- Chain of up to DEPTH pipeline stages with a runtime-selectable output tap, so latency can be chosen per configuration without resynthesis.
- Valid flag travels with the data; a settle counter masks stale output whenever the selected latency changes.
- Used on A/B/C/D/P paths wherever a balanced, reconfigurable delay is needed.

---
 rtl/dsp_pipe_pkg.sv | 20 ++
 rtl/dsp_pipe_stage.sv | 34 +++
 rtl/dsp_pipe_delay_line.sv | 95 +++++++++
 3 files changed

// File: rtl/dsp_pipe_pkg.sv
// Shared parameters and elaboration helpers for the reconfigurable DSP delay line.
package dsp_pipe_pkg;

    localparam int MAX_DEPTH = 16;

    // Width needed to encode 0..depth inclusive.
    function automatic int clog2_p1(input int depth);
        int r;
        r = 0;
        while ((1 << r) < (depth + 1)) begin
            r++;
        end
        return r;
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= 1) && (depth <= MAX_DEPTH);
    endfunction

endpackage

// File: rtl/dsp_pipe_stage.sv
// One pipeline stage: data plus valid flag, async reset, clock enable, gated sync clear.
module dsp_pipe_stage
    import dsp_pipe_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             sclr,
    input  logic [WIDTH-1:0] d,
    input  logic             d_vld,
    output logic [WIDTH-1:0] q,
    output logic             q_vld
);

    logic [WIDTH:0] reg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_q <= '0;
        end else if (ce) begin
            if (sclr) begin
                reg_q <= '0;
            end else begin
                reg_q <= {d_vld, d};
            end
        end
    end

    assign q     = reg_q[WIDTH-1:0];
    assign q_vld = reg_q[WIDTH];

endmodule

// File: rtl/dsp_pipe_delay_line.sv
// Delay line of up to DEPTH stages with runtime-selected tap and output masking after latency changes.
module dsp_pipe_delay_line
    import dsp_pipe_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4,
    parameter int LW    = clog2_p1(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             sclr,
    input  logic [WIDTH-1:0] d_in,
    input  logic             d_in_vld,
    input  logic [LW-1:0]    lat_sel,
    output logic [WIDTH-1:0] d_out,
    output logic             d_out_vld,
    output logic             settling,
    output logic             lat_err
);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("dsp_pipe_delay_line: DEPTH must be within 1..MAX_DEPTH");
    end

    logic [WIDTH-1:0] stage_d [DEPTH];
    logic             stage_v [DEPTH];
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic             vld_q   [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign stage_d[g] = d_in;
            assign stage_v[g] = d_in_vld;
        end else begin : g_body
            assign stage_d[g] = stage_q[g-1];
            assign stage_v[g] = vld_q[g-1];
        end

        dsp_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk  (clk),
            .rst  (rst),
            .ce   (ce),
            .sclr (sclr),
            .d    (stage_d[g]),
            .d_vld(stage_v[g]),
            .q    (stage_q[g]),
            .q_vld(vld_q[g])
        );
    end

    logic [LW-1:0] lat_eff;
    logic [LW-1:0] lat_q;
    logic [LW-1:0] settle_cnt;
    logic          changed;
    logic          raw_vld;

    assign lat_err = (lat_sel > LW'(DEPTH));
    assign lat_eff = lat_err ? LW'(DEPTH) : lat_sel;
    assign changed = (lat_eff != lat_q);

    always_comb begin
        d_out   = d_in;
        raw_vld = d_in_vld;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (lat_eff == LW'(i + 1)) begin
                d_out   = stage_q[i];
                raw_vld = vld_q[i];
            end
        end
    end

    // A latency change reloads the counter even with ce low, so in-flight samples stay masked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_q      <= '0;
            settle_cnt <= '0;
        end else if (changed) begin
            lat_q      <= lat_eff;
            settle_cnt <= (lat_eff == '0) ? '0 : lat_eff - LW'(1);
        end else if (ce) begin
            if (sclr) begin
                settle_cnt <= '0;
            end else if (settle_cnt != '0) begin
                settle_cnt <= settle_cnt - LW'(1);
            end
        end
    end

    assign settling  = changed | (settle_cnt != '0);
    assign d_out_vld = raw_vld & ~settling;

endmodule
